apb_intercon_rr: RTL and testbench
==================================

# apb_intercon_rr

Multi-master to multi-slave APB interconnect that replaces the free-running rotating-grant interconnect in the cluster SoC. It grants the bus only to requesting masters using round-robin order and locks the grant for a whole SETUP/ACCESS transfer. It registers the transfer address, direction and write data, and decodes the slave select from an address field. It returns an error response for unmapped addresses and for slaves that fail to respond within a timeout. It sits between the core APB master ports and the peripheral slaves (GPIO, UART, timers, shared memory).

## Interface
- BUS_WIDTH, 16, address width
- DATA_WIDTH, 16, data width
- MASTER_PORTS, 4, number of masters (≥1)
- ADDR_MSB, 7, top bit of slave-select field
- ADDR_LSB, 4, bottom bit of slave-select field
- SLAVE_PORTS, 16, number of mapped slaves (1 … 2^(ADDR_MSB-ADDR_LSB+1))
- TIMEOUT, 255, maximum ACCESS cycles before an error response; 0 disables the timeout
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- S_PADDR  in  MASTER_PORTS*BUS_WIDTH  master addresses
- S_PWRITE  in  MASTER_PORTS  master write flags
- S_PSELx  in  MASTER_PORTS  master requests
- S_PENABLE  in  MASTER_PORTS  master enables; ignored, the interconnect generates its own phase
- S_PWDATA  in  MASTER_PORTS*DATA_WIDTH  master write data
- S_PRDATA  out  MASTER_PORTS*DATA_WIDTH  read data; valid only in the granted master's lane
- S_PREADY  out  MASTER_PORTS  transfer-complete flags, one-hot or zero
- S_PSLVERR  out  MASTER_PORTS  error flags, qualified by S_PREADY
- M_PADDR  out  BUS_WIDTH  registered address to the slaves
- M_PWRITE  out  1  registered write flag
- M_PSELx  out  SLAVE_PORTS  one-hot slave select
- M_PENABLE  out  1  access phase
- M_PWDATA  out  DATA_WIDTH  registered write data
- M_PRDATA  in  SLAVE_PORTS*DATA_WIDTH  slave read data
- M_PREADY  in  SLAVE_PORTS  slave ready flags
- M_PSLVERR  in  SLAVE_PORTS  slave error flags
- GRANT  out  MASTER_PORTS  one-hot current owner; zero in IDLE

## Operation
- FSM has three states: IDLE, SETUP and ACCESS.
- **IDLE:**
  - If any S_PSELx is high, pick the first requester at or after `last+1`, wrapping round.
  - Latch that requester's address, write flag and write data into M_PADDR, M_PWRITE and M_PWDATA.
  - Latch the decoded slave index `idx = PADDR[ADDR_MSB:ADDR_LSB]`, set GRANT, and go to SETUP.
  - If no master requests, stay in IDLE.
- **SETUP:**
  - M_PSELx[idx] = 1 and M_PENABLE = 0.
  - If idx ≥ SLAVE_PORTS, the address is unmapped: M_PSELx stays zero.
  - Next state is always ACCESS.
- **ACCESS:**
  - M_PSELx[idx] = 1 and M_PENABLE = 1.
  - S_PRDATA[g] = M_PRDATA[idx] and S_PSLVERR[g] = M_PSLVERR[idx], combinationally.
  - Completion happens in the cycle M_PREADY[idx] = 1. S_PREADY[g] = 1 in that cycle, and the next state is IDLE with `last = g`.
  - Unmapped address: complete in the first ACCESS cycle with S_PSLVERR[g] = 1 and S_PRDATA = 0.
  - Timeout: a counter clears on entry to ACCESS. If it reaches TIMEOUT-1 without M_PREADY, complete in that cycle with S_PSLVERR[g] = 1 and S_PRDATA = 0.
- Only the granted master ever sees S_PREADY; all other lanes are 0.
- If a master drops S_PSELx mid-transfer, the interconnect still completes the transfer to the slave. The response is driven but may be ignored.
- Masters hold PSEL high until they see PREADY. A master that re-requests immediately after completion loses priority to any other pending requester.

## Timing
- Reset, and the values in IDLE:
  - State IDLE, `last = MASTER_PORTS-1` so master 0 has first priority, timeout counter 0.
  - M_PADDR, M_PWRITE and M_PWDATA reset to 0 and keep their values in IDLE.
  - M_PSELx, M_PENABLE, GRANT, S_PREADY, S_PSLVERR and S_PRDATA are 0.
- Reset during SETUP or ACCESS aborts the transfer. At the next edge all outputs return to their reset values, and no S_PREADY is issued.
- Latency with a zero-wait slave:
  - Request sampled at edge E0.
  - SETUP in cycle 1, ACCESS in cycle 2 with S_PREADY high.
  - IDLE in cycle 3, earliest new grant at edge E3.
  - Minimum transfer spacing is 3 cycles.
- Each slave wait state adds one cycle.
- With TIMEOUT = N, the worst case is N ACCESS cycles.
- Arbitration is evaluated only in IDLE; a request arriving during a transfer waits.
- M_PADDR, M_PWRITE and M_PWDATA are stable from SETUP through completion.

## Test plan
- **Single read:** master 0 requests a read at 0x0025 and slave 2 responds with PREADY in the first ACCESS cycle and PRDATA = 0xBEEF. Required: M_PSELx = 0x0004; S_PRDATA lane 0 = 0xBEEF with S_PREADY[0] high 2 cycles after the request; PSLVERR = 0.
- **Contention:** masters 0, 1 and 3 request continuously with zero-wait slaves. Required: grant order 0, 1, 3, 0, 1, 3; each transfer takes exactly 3 cycles.
- **Wait states:** slave 5 holds PREADY low for 4 ACCESS cycles. Required: S_PREADY rises in the 5th ACCESS cycle; M_PADDR and M_PWDATA stay unchanged throughout.
- **Unmapped address:** SLAVE_PORTS = 4 and the address is 0x0070. Required: M_PSELx = 0; S_PREADY and S_PSLVERR high in the first ACCESS cycle; S_PRDATA = 0.
- **Timeout:** TIMEOUT = 8 and the slave never asserts ready. Required: S_PREADY and S_PSLVERR high in ACCESS cycle 8; FSM returns to IDLE.
- **Reset mid-transfer:** reset is asserted during ACCESS. Required: the next cycle has all outputs zero and no S_PREADY; after release, master 0 is granted first.

Source files
------------

// File: rtl/apb_intercon_rr.sv
// Multi-master to multi-slave APB interconnect. Masters are granted in round-robin order,
// and each grant is held for one full SETUP/ACCESS transfer with registered address/data.
module apb_intercon_rr #(
   parameter int BUS_WIDTH    = 16,
   parameter int DATA_WIDTH   = 16,
   parameter int MASTER_PORTS = 4,
   parameter int ADDR_MSB     = 7,
   parameter int ADDR_LSB     = 4,
   parameter int SLAVE_PORTS  = 16,
   parameter int TIMEOUT      = 255
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
   input  logic [MASTER_PORTS-1:0]            S_PWRITE,
   input  logic [MASTER_PORTS-1:0]            S_PSELx,
   input  logic [MASTER_PORTS-1:0]            S_PENABLE,
   input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
   output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
   output logic [MASTER_PORTS-1:0]            S_PREADY,
   output logic [MASTER_PORTS-1:0]            S_PSLVERR,
   output logic [BUS_WIDTH-1:0]               M_PADDR,
   output logic                               M_PWRITE,
   output logic [SLAVE_PORTS-1:0]             M_PSELx,
   output logic                               M_PENABLE,
   output logic [DATA_WIDTH-1:0]              M_PWDATA,
   input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
   input  logic [SLAVE_PORTS-1:0]             M_PREADY,
   input  logic [SLAVE_PORTS-1:0]             M_PSLVERR,
   output logic [MASTER_PORTS-1:0]            GRANT,
   output logic [1:0]                         state_dbg
);

   // Handshake: on the master side S_PSELx is the request (valid), held until the master
   // sees its S_PREADY lane, which pulses for exactly the completing ACCESS cycle. On the
   // slave side a transfer is SETUP then ACCESS, ending in the cycle the selected slave
   // raises M_PREADY, or early with an error on an unmapped address or a timeout.

   localparam int MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
   localparam int IW = ADDR_MSB - ADDR_LSB + 1;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t          state;
   logic [MW-1:0]   last;
   logic [MW-1:0]   gidx;
   logic [IW-1:0]   sidx;
   logic            mapped;
   logic [CW-1:0]   cnt;

   logic                    found;
   logic [MW-1:0]           cand;
   logic [MW-1:0]           win;
   logic [MASTER_PORTS-1:0] win_grant;
   logic [BUS_WIDTH-1:0]    win_addr;
   logic                    win_write;
   logic [DATA_WIDTH-1:0]   win_wdata;
   logic [IW-1:0]           win_sidx;
   logic                    win_mapped;
   logic [SLAVE_PORTS-1:0]  win_sel;

   logic                    sel_rdy;
   logic                    sel_err;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    timed_out;
   logic                    done;
   logic                    resp_err;
   logic [DATA_WIDTH-1:0]   resp_data;

   logic unused_penable;
   assign unused_penable = ^S_PENABLE;
   assign state_dbg = state;

   // Search starts one past the last owner, so a master that just finished yields to others.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      win   = last;
      for (int i = 1; i <= MASTER_PORTS; i++) begin
         cand = MW'((int'(last) + i) % MASTER_PORTS);
         if (!found && S_PSELx[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      win_grant = '0;
      win_addr  = '0;
      win_write = 1'b0;
      win_wdata = '0;
      for (int m = 0; m < MASTER_PORTS; m++) begin
         if (win == MW'(m)) begin
            win_grant[m] = 1'b1;
            win_addr     = S_PADDR[m*BUS_WIDTH +: BUS_WIDTH];
            win_write    = S_PWRITE[m];
            win_wdata    = S_PWDATA[m*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      win_sidx   = win_addr[ADDR_MSB:ADDR_LSB];
      win_mapped = (int'(win_sidx) < SLAVE_PORTS);
      win_sel    = '0;
      for (int j = 0; j < SLAVE_PORTS; j++) begin
         win_sel[j] = (win_sidx == IW'(j));
      end
   end

   always_comb begin
      sel_rdy  = 1'b0;
      sel_err  = 1'b0;
      sel_data = '0;
      for (int j = 0; j < SLAVE_PORTS; j++) begin
         if (sidx == IW'(j)) begin
            sel_rdy  = M_PREADY[j];
            sel_err  = M_PSLVERR[j];
            sel_data = M_PRDATA[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      timed_out = (TIMEOUT != 0) && (cnt == TO_LAST);
      done      = !mapped || sel_rdy || timed_out;
      if (!mapped || (!sel_rdy && timed_out)) begin
         resp_err  = 1'b1;
         resp_data = '0;
      end else begin
         resp_err  = sel_err;
         resp_data = sel_data;
      end
   end

   always_comb begin
      S_PREADY  = '0;
      S_PSLVERR = '0;
      S_PRDATA  = '0;
      if (state == ACCESS) begin
         for (int m = 0; m < MASTER_PORTS; m++) begin
            if (gidx == MW'(m)) begin
               S_PREADY[m]                         = done;
               S_PSLVERR[m]                        = resp_err;
               S_PRDATA[m*DATA_WIDTH +: DATA_WIDTH] = resp_data;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last      <= MW'(MASTER_PORTS - 1);
         gidx      <= '0;
         sidx      <= '0;
         mapped    <= 1'b0;
         cnt       <= '0;
         M_PADDR   <= '0;
         M_PWRITE  <= 1'b0;
         M_PWDATA  <= '0;
         M_PSELx   <= '0;
         M_PENABLE <= 1'b0;
         GRANT     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  gidx     <= win;
                  GRANT    <= win_grant;
                  M_PADDR  <= win_addr;
                  M_PWRITE <= win_write;
                  M_PWDATA <= win_wdata;
                  sidx     <= win_sidx;
                  mapped   <= win_mapped;
                  M_PSELx  <= win_sel;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               M_PENABLE <= 1'b1;
               cnt       <= '0;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (done) begin
                  last      <= gidx;
                  GRANT     <= '0;
                  M_PSELx   <= '0;
                  M_PENABLE <= 1'b0;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// Bench for apb_intercon_rr: a per-cycle vector table for reset, single read and contention,
// then hand sequences for wait states, unmapped address, timeout and reset mid-transfer.
module tb_apb_intercon_rr;

   localparam int BW = 16;
   localparam int DW = 16;
   localparam int MP = 4;
   localparam int SP = 6;
   localparam int NV = 26;

   localparam logic [63:0] R0 = 64'h0;
   localparam logic [63:0] RB = 64'h0000_0000_0000_BEEF;
   localparam logic [63:0] R3 = 64'h0000_0000_A003_0000;
   localparam logic [63:0] R1 = 64'hA001_0000_0000_0000;
   localparam logic [63:0] R5 = 64'h0000_A005_0000_0000;

   logic              clk = 1'b0;
   logic              reset;
   logic [MP*BW-1:0]  s_paddr;
   logic [MP-1:0]     s_pwrite;
   logic [MP-1:0]     s_psel;
   logic [MP*DW-1:0]  s_pwdata;
   logic [MP*DW-1:0]  s_prdata;
   logic [MP-1:0]     s_pready;
   logic [MP-1:0]     s_pslverr;
   logic [BW-1:0]     m_paddr;
   logic              m_pwrite;
   logic [SP-1:0]     m_psel;
   logic              m_penable;
   logic [DW-1:0]     m_pwdata;
   logic [SP*DW-1:0]  m_prdata;
   logic [SP-1:0]     m_pready;
   logic [SP-1:0]     m_pslverr;
   logic [MP-1:0]     grant;
   logic [1:0]        state_dbg;

   // clock / reset block
   always #5 clk = ~clk;
   initial reset = 1'b1;

   apb_intercon_rr #(
      .BUS_WIDTH(BW), .DATA_WIDTH(DW), .MASTER_PORTS(MP), .ADDR_MSB(7), .ADDR_LSB(4),
      .SLAVE_PORTS(SP), .TIMEOUT(8)
   ) dut (
      .clk(clk), .reset(reset),
      .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel), .S_PENABLE(s_psel),
      .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready), .S_PSLVERR(s_pslverr),
      .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel), .M_PENABLE(m_penable),
      .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready), .M_PSLVERR(m_pslverr),
      .GRANT(grant), .state_dbg(state_dbg)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  psel;
      logic [5:0]  mrdy;
      logic [1:0]  e_state;
      logic [3:0]  e_grant;
      logic [5:0]  e_msel;
      logic        e_men;
      logic [15:0] e_paddr;
      logic        e_pwr;
      logic [15:0] e_wdata;
      logic [3:0]  e_srdy;
      logic [3:0]  e_serr;
      logic [63:0] e_rdata;
   } vec_t;

   vec_t tbl [NV];

   int checks   = 0;
   int failures = 0;

   // scoreboard of completion lanes
   logic [MP-1:0] exp_q [$];
   logic [MP-1:0] got_q [$];

   always @(negedge clk) begin
      if (|s_pready) got_q.push_back(s_pready);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_row(input string tag, input vec_t v);
      check({tag, "_state"}, 64'(state_dbg), 64'(v.e_state));
      check({tag, "_grant"}, 64'(grant), 64'(v.e_grant));
      check({tag, "_msel"}, 64'(m_psel), 64'(v.e_msel));
      check({tag, "_menable"}, 64'(m_penable), 64'(v.e_men));
      check({tag, "_paddr"}, 64'(m_paddr), 64'(v.e_paddr));
      check({tag, "_pwrite"}, 64'(m_pwrite), 64'(v.e_pwr));
      check({tag, "_pwdata"}, 64'(m_pwdata), 64'(v.e_wdata));
      check({tag, "_spready"}, 64'(s_pready), 64'(v.e_srdy));
      check({tag, "_spslverr"}, 64'(s_pslverr), 64'(v.e_serr));
      check({tag, "_sprdata"}, 64'(s_prdata), v.e_rdata);
   endtask

   initial begin
      vec_t z;
      s_psel   = '0;
      m_pready = '0;
      s_paddr  = {16'h0014, 16'h0050, 16'h0031, 16'h0025};
      s_pwrite = 4'b1110;
      s_pwdata = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
      m_prdata = {16'hA005, 16'hA004, 16'hA003, 16'hBEEF, 16'hA001, 16'hA000};
      m_pslverr = 6'b001000;

      tbl[0]  = '{1'b1, 4'h0, 6'h00, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, R0};
      tbl[1]  = '{1'b0, 4'h1, 6'h00, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, R0};
      tbl[2]  = '{1'b0, 4'h1, 6'h04, 2'd1, 4'h1, 6'h04, 1'b0, 16'h0025, 1'b0, 16'h0F0F, 4'h0, 4'h0, R0};
      tbl[3]  = '{1'b0, 4'h1, 6'h04, 2'd2, 4'h1, 6'h04, 1'b1, 16'h0025, 1'b0, 16'h0F0F, 4'h1, 4'h0, RB};
      tbl[4]  = '{1'b0, 4'h0, 6'h00, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0025, 1'b0, 16'h0F0F, 4'h0, 4'h0, R0};
      tbl[5]  = '{1'b1, 4'hB, 6'h00, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0025, 1'b0, 16'h0F0F, 4'h0, 4'h0, R0};
      tbl[6]  = '{1'b0, 4'hB, 6'h3F, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, R0};
      tbl[7]  = '{1'b0, 4'hB, 6'h3F, 2'd1, 4'h1, 6'h04, 1'b0, 16'h0025, 1'b0, 16'h0F0F, 4'h0, 4'h0, R0};
      tbl[8]  = '{1'b0, 4'hB, 6'h3F, 2'd2, 4'h1, 6'h04, 1'b1, 16'h0025, 1'b0, 16'h0F0F, 4'h1, 4'h0, RB};
      tbl[9]  = '{1'b0, 4'hB, 6'h3F, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0025, 1'b0, 16'h0F0F, 4'h0, 4'h0, R0};
      tbl[10] = '{1'b0, 4'hB, 6'h3F, 2'd1, 4'h2, 6'h08, 1'b0, 16'h0031, 1'b1, 16'h1111, 4'h0, 4'h0, R0};
      tbl[11] = '{1'b0, 4'hB, 6'h3F, 2'd2, 4'h2, 6'h08, 1'b1, 16'h0031, 1'b1, 16'h1111, 4'h2, 4'h2, R3};
      tbl[12] = '{1'b0, 4'hB, 6'h3F, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0031, 1'b1, 16'h1111, 4'h0, 4'h0, R0};
      tbl[13] = '{1'b0, 4'hB, 6'h3F, 2'd1, 4'h8, 6'h02, 1'b0, 16'h0014, 1'b1, 16'h3333, 4'h0, 4'h0, R0};
      tbl[14] = '{1'b0, 4'hB, 6'h3F, 2'd2, 4'h8, 6'h02, 1'b1, 16'h0014, 1'b1, 16'h3333, 4'h8, 4'h0, R1};
      tbl[15] = '{1'b0, 4'hB, 6'h3F, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0014, 1'b1, 16'h3333, 4'h0, 4'h0, R0};
      // second round of the contention cycle: same 0,1,3 pattern
      for (int k = 16; k <= 24; k++) tbl[k] = tbl[k-9];
      tbl[23].psel = 4'h0;
      tbl[24].psel = 4'h0;
      tbl[25] = tbl[24];
      tbl[25].mrdy = 6'h00;

      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         tick();
         reset    = tbl[i].rst;
         s_psel   = tbl[i].psel;
         m_pready = tbl[i].mrdy;
         #1;
         if (tbl[i].e_srdy != 4'h0) exp_q.push_back(tbl[i].e_srdy);
         check_row($sformatf("row%0d", i), tbl[i]);
      end

      // wait states: slave 5 ready only in the 5th ACCESS cycle
      s_psel = 4'h4;
      tick();
      #1;
      check("ws_setup_state", 64'(state_dbg), 64'd1);
      check("ws_setup_grant", 64'(grant), 64'h4);
      check("ws_setup_msel", 64'(m_psel), 64'h20);
      for (int c = 1; c <= 5; c++) begin
         tick();
         m_pready = (c == 5) ? 6'h20 : 6'h00;
         #1;
         check($sformatf("ws_c%0d_state", c), 64'(state_dbg), 64'd2);
         check($sformatf("ws_c%0d_paddr", c), 64'(m_paddr), 64'h0050);
         check($sformatf("ws_c%0d_pwdata", c), 64'(m_pwdata), 64'h2222);
         check($sformatf("ws_c%0d_spready", c), 64'(s_pready), (c == 5) ? 64'h4 : 64'h0);
      end
      exp_q.push_back(4'h4);
      check("ws_rdata", 64'(s_prdata), R5);
      check("ws_slverr", 64'(s_pslverr), 64'h0);
      s_psel = 4'h0;
      tick();
      m_pready = 6'h00;
      #1;
      check("ws_idle_state", 64'(state_dbg), 64'd0);

      // unmapped address (slave field 7 with 6 slaves)
      s_paddr[2*BW +: BW] = 16'h0070;
      s_psel = 4'h4;
      tick();
      #1;
      check("um_setup_state", 64'(state_dbg), 64'd1);
      check("um_setup_msel", 64'(m_psel), 64'h0);
      check("um_setup_paddr", 64'(m_paddr), 64'h0070);
      tick();
      #1;
      exp_q.push_back(4'h4);
      check("um_acc_msel", 64'(m_psel), 64'h0);
      check("um_acc_spready", 64'(s_pready), 64'h4);
      check("um_acc_slverr", 64'(s_pslverr), 64'h4);
      check("um_acc_rdata", 64'(s_prdata), R0);
      s_psel = 4'h0;
      tick();
      #1;
      check("um_idle_state", 64'(state_dbg), 64'd0);

      // timeout: slave 5 never ready, error in ACCESS cycle 8
      s_paddr[2*BW +: BW] = 16'h0050;
      s_psel = 4'h4;
      tick();
      #1;
      check("to_setup_state", 64'(state_dbg), 64'd1);
      for (int c = 1; c <= 8; c++) begin
         tick();
         #1;
         check($sformatf("to_c%0d_state", c), 64'(state_dbg), 64'd2);
         check($sformatf("to_c%0d_spready", c), 64'(s_pready), (c == 8) ? 64'h4 : 64'h0);
         check($sformatf("to_c%0d_slverr", c), 64'(s_pslverr), (c == 8) ? 64'h4 : 64'h0);
      end
      exp_q.push_back(4'h4);
      check("to_rdata", 64'(s_prdata), R0);
      s_psel = 4'h0;
      tick();
      #1;
      check("to_idle_state", 64'(state_dbg), 64'd0);
      check("to_idle_grant", 64'(grant), 64'h0);

      // reset during ACCESS, then master 0 must win over all requesters
      s_psel = 4'h4;
      tick();
      tick();
      #1;
      check("rst_pre_state", 64'(state_dbg), 64'd2);
      reset = 1'b1;
      #1;
      check("rst_pre_spready", 64'(s_pready), 64'h0);
      tick();
      reset    = 1'b0;
      s_psel   = 4'hF;
      m_pready = 6'h3F;
      #1;
      z = '{1'b0, 4'h0, 6'h00, 2'd0, 4'h0, 6'h00, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, R0};
      check_row("rst_post", z);
      tick();
      #1;
      check("rst_regrant_state", 64'(state_dbg), 64'd1);
      check("rst_regrant_grant", 64'(grant), 64'h1);
      check("rst_regrant_paddr", 64'(m_paddr), 64'h0025);
      tick();
      #1;
      exp_q.push_back(4'h1);
      check("rst_regrant_spready", 64'(s_pready), 64'h1);
      check("rst_regrant_rdata", 64'(s_prdata), RB);
      s_psel = 4'h0;
      tick();
      tick();

      check("sb_count", 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("sb_lane%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
